dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares one single-port synchronous data RAM between the two CPU cores' data-memory ports (p0, p1).
- Replaces the fixed-priority write-conflict gating with round-robin arbitration, a lock for atomic read-modify-write, a lock timeout and out-of-range handling.
- Sits between the cpu data ports and the DM RAM instance in the top level.

Parameters:
- ADDR_W, 9, requester address width
- MEM_AW, 8, RAM address width; addresses >= 2**MEM_AW are out of range
- DATA_W, 16, data width
- LOCK_TIMEOUT, 64, idle cycles after which a held lock is forcibly released

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- pN_req  in  1  access request, N=0,1; held with its fields until granted
- pN_we  in  1  1=write, 0=read
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data
- pN_lock  in  1  keep ownership after this access
- pN_gnt  out  1  access accepted this cycle
- pN_rvalid  out  1  read data valid, one cycle after gnt of a read
- pN_rdata  out  DATA_W  read data, 0 when pN_rvalid=0
- pN_err  out  1  pulses with rvalid or in the cycle after gnt for an out-of-range access
- mem_addr  out  MEM_AW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- lock_owner  out  2  00 none, 01 p0, 10 p1
- lock_timeout  out  1  one-cycle pulse on forced release

Behaviour:
Reset:
- While rst_n=0 sampled at a clock edge, all gnt, rvalid, err, mem_we, lock_timeout and lock_owner outputs are 0.
- The last-winner pointer resets to p1, so p0 wins the first contention.
- The timeout counter resets to 0.
- Reset in the middle of a lock or a read drops both; no rvalid is issued afterwards.

Arbitration:
- Combinational, one grant per cycle.
- Only one requester: it is granted unless the other core holds the lock.
- Both requesting, no lock: grant the one that is not the last winner.
- The pointer updates only on a grant.

Memory drive:
- mem_addr, mem_we and mem_wdata come from the granted requester.
- mem_we = gnt & we & in-range.
- With no grant: mem_we=0; mem_addr and mem_wdata hold their previous values (registered copy).

Read path:
- A granted read registers (port, in-range) for one cycle.
- Next cycle: that port's rvalid=1 and rdata=mem_rdata (0 if out of range).
- Throughput is one access per cycle. Back-to-back reads from the same port give rvalid on consecutive cycles.

Out-of-range accesses (addr[ADDR_W-1:MEM_AW] != 0):
- Still granted.
- Writes are dropped; reads return 0.
- err pulses one cycle after the grant.

Lock state machine (UNLOCKED, LOCK0, LOCK1):
- UNLOCKED -> LOCKn: on a grant to pN with pN_lock=1.
- LOCKn -> UNLOCKED: on a grant to pN with pN_lock=0. That access still completes.
- While in LOCKn, the other port is never granted.
- Timeout counter:
  - clears on any grant to the owner;
  - increments each LOCKn cycle in which owner req=0;
  - at LOCK_TIMEOUT-1 the next edge returns to UNLOCKED with a lock_timeout pulse.
- LOCKn with pN_lock=1 on further grants: remains LOCKn.

Other boundaries:
- Simultaneous requests in the cycle of release: the releasing access has the grant. The waiter is granted next cycle by normal round-robin.
- gnt never asserts without req.
- Both gnt are never 1 together.

Decomposition:
- Package dm_arb_pkg holds:
  - lock_state_t enum (UNLOCKED, LOCK0, LOCK1)
  - owner encoding constants OWN_NONE, OWN_P0, OWN_P1
  - default widths
- One sub-module, rr_arb2: 2-way round-robin picker (req[1:0], last, mask[1:0] -> gnt[1:0]).
- Lock FSM, timeout counter and read-return pipeline stay in dm_arbiter.

Test Plan:
1. Write then read, p0 only: p0 writes 16'hBEEF to 0x012, then p0 reads 0x012 -> gnt same cycle each; next cycle p0_rvalid=1, p0_rdata=16'hBEEF; p1 outputs stay 0.
2. Contention, both ports request reads of 0x020 and 0x021 for 4 cycles after reset -> grants alternate p0, p1, p0, p1; each rvalid one cycle after its gnt, on the correct port.
3. Lock:
   - p0 reads 0x030 with lock=1 while p1 holds a request;
   - p0 writes 0x030 = old+1 with lock=0 -> p1 has no gnt until the cycle after p0's unlocking write; lock_owner 01 -> 00.
4. Timeout, LOCK_TIMEOUT=4:
   - p1 takes the lock, then drops req; p0 is requesting -> lock_timeout pulses after 4 idle cycles;
   - p0 is granted the following cycle.
5. Out of range:
   - p1 writes 16'h1234 to 0x1FF -> mem_we=0, p1_err pulses;
   - p1 then reads 0x1FF -> rdata=0, err=1;
   - RAM address 0xFF is unchanged.
6. Reset mid-read: rst_n low in the cycle after a p0 read grant -> no rvalid, lock_owner=00, and p0 wins the next contention.

Source files
------------

// File: rtl/dm_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dm_arb_pkg                                                 |
// | Description : Shared types and constants for the dual-core data-memory   |
// |               arbiter: lock FSM states, lock-owner encodings and default |
// |               bus widths.                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package dm_arb_pkg;

  localparam int DEF_ADDR_W       = 9;
  localparam int DEF_MEM_AW       = 8;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_LOCK_TIMEOUT = 64;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;

  // Map a lock state onto the externally visible owner code.
  function automatic logic [1:0] owner_of(input lock_state_t s);
    logic [1:0] o;
    o = OWN_NONE;
    case (s)
      LOCK0:   o = OWN_P0;
      LOCK1:   o = OWN_P1;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dm_arbiter_if                                              |
// | Description : Bus bundle between the two CPU data ports, the arbiter and |
// |               the single-port DM RAM.                                    |
// |   pN_req/we/addr/wdata/lock : requester access fields (N = 0,1)          |
// |   pN_gnt/rvalid/rdata/err   : arbiter responses                          |
// |   mem_addr/we/wdata/rdata   : RAM side (rdata has 1-cycle latency)       |
// |   lock_owner/lock_timeout   : lock status                                |
// |   modport slave  : arbiter view;  modport master : CPU/RAM/bench view    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int DATA_W = DEF_DATA_W
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_lock;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_lock;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        lock_owner;
  logic              lock_timeout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output lock_owner, lock_timeout
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  lock_owner, lock_timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arb2                                                    |
// | Description : Combinational 2-way round-robin picker.                    |
// |   req[1:0]  : raw requests                                               |
// |   last      : last winner (0 = p0, 1 = p1)                               |
// |   mask[1:0] : 1 blocks that requester this cycle                         |
// |   gnt[1:0]  : one-hot (or zero) grant                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] w_req;

  assign w_req = req & ~mask;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (w_req[0] && (!w_req[1] || last)) begin
      gnt = 2'b01;
    end else if (w_req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dm_arbiter                                                 |
// | Description : Shares one single-port synchronous DM RAM between two CPU  |
// |               data ports with round-robin arbitration, a lock for atomic |
// |               read-modify-write, a lock timeout and out-of-range access  |
// |               handling.                                                  |
// |   clk   : system clock, rising edge                                      |
// |   rst_n : synchronous reset, active low                                  |
// |   bus   : dm_arbiter_if.slave (requesters, RAM port, lock status)        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MEM_AW       = DEF_MEM_AW,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  localparam int              CNT_W   = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

  lock_state_t       r_state;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_lock_to;
  logic [1:0]        r_rd_port;
  logic              r_rd_inr;
  logic [1:0]        r_err;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [1:0]        w_req;
  logic [1:0]        w_mask;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic              w_we;
  logic              w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_inr;
  logic              w_owner_req;

  // Requests are blanked during reset so no grant or RAM write escapes.
  assign w_req = {bus.p1_req, bus.p0_req} & {2{rst_n}};

  always_comb begin
    w_mask      = 2'b00;
    w_owner_req = 1'b0;
    case (r_state)
      LOCK0: begin
        w_mask      = 2'b10;
        w_owner_req = bus.p0_req;
      end
      LOCK1: begin
        w_mask      = 2'b01;
        w_owner_req = bus.p1_req;
      end
      default: begin
        w_mask      = 2'b00;
        w_owner_req = 1'b0;
      end
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (r_last),
    .mask (w_mask),
    .gnt  (w_gnt)
  );

  assign w_any   = |w_gnt;
  assign w_sel   = w_gnt[1];
  assign w_we    = w_sel ? bus.p1_we    : bus.p0_we;
  assign w_lock  = w_sel ? bus.p1_lock  : bus.p0_lock;
  assign w_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
  assign w_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;
  assign w_inr   = ((w_addr >> MEM_AW) == '0);

  assign bus.p0_gnt = w_gnt[0];
  assign bus.p1_gnt = w_gnt[1];

  // Address/data follow the winner; otherwise the last granted values are held.
  assign bus.mem_addr  = w_any ? w_addr[MEM_AW-1:0] : r_mem_addr;
  assign bus.mem_wdata = w_any ? w_wdata : r_mem_wdata;
  assign bus.mem_we    = w_any & w_we & w_inr;

  // Read return is blanked while reset is asserted so an in-flight read is dropped.
  assign bus.p0_rvalid = r_rd_port[0] & rst_n;
  assign bus.p1_rvalid = r_rd_port[1] & rst_n;
  assign bus.p0_rdata  = (r_rd_port[0] & r_rd_inr & rst_n) ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = (r_rd_port[1] & r_rd_inr & rst_n) ? bus.mem_rdata : '0;
  assign bus.p0_err    = r_err[0] & rst_n;
  assign bus.p1_err    = r_err[1] & rst_n;

  assign bus.lock_owner   = owner_of(r_state);
  assign bus.lock_timeout = r_lock_to;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= UNLOCKED;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_lock_to   <= 1'b0;
      r_rd_port   <= 2'b00;
      r_rd_inr    <= 1'b0;
      r_err       <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_lock_to <= 1'b0;
      r_rd_port <= w_gnt & {2{~w_we}};
      r_rd_inr  <= w_inr;
      r_err     <= w_gnt & {2{~w_inr}};

      if (w_any) begin
        r_last      <= w_sel;
        r_mem_addr  <= w_addr[MEM_AW-1:0];
        r_mem_wdata <= w_wdata;
      end

      case (r_state)
        UNLOCKED: begin
          r_cnt <= '0;
          if (w_any && w_lock) begin
            r_state <= w_sel ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          // While locked only the owner can be granted, so any grant is the owner's.
          if (w_any) begin
            r_cnt <= '0;
            if (!w_lock) begin
              r_state <= UNLOCKED;
            end
          end else if (!w_owner_req) begin
            if (r_cnt == CNT_MAX) begin
              r_state   <= UNLOCKED;
              r_cnt     <= '0;
              r_lock_to <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= UNLOCKED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dm_arbiter                                              |
// | Description : Directed self-checking bench for dm_arbiter with a simple  |
// |               1-cycle-latency RAM model (word i preset to 16'h1000+i).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [15:0] ram [0:255];
  logic        ram_ready = 1'b0;

  dm_arbiter_if #(.ADDR_W(9), .MEM_AW(8), .DATA_W(16)) bus ();

  dm_arbiter #(
    .ADDR_W(9), .MEM_AW(8), .DATA_W(16), .LOCK_TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'(16'h1000 + i);
      ram_ready <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_lock = 1'b0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
  endtask

  task automatic drive0(input logic we, input logic [8:0] a, input logic [15:0] d, input logic lk);
    bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_lock = lk;
  endtask

  task automatic drive1(input logic we, input logic [8:0] a, input logic [15:0] d, input logic lk);
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_lock = lk;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.p0_addr = '0; bus.p0_wdata = '0; bus.p1_addr = '0; bus.p1_wdata = '0;
    idle();
    drive0(1'b1, 9'h012, 16'hDEAD, 1'b1);
    drive1(1'b0, 9'h013, 16'h0000, 1'b1);
    step();
    mid();
    n_total++; if (bus.p0_gnt !== 1'b0) $display("FAIL rst_p0_gnt: got %b exp 0", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.p1_gnt !== 1'b0) $display("FAIL rst_p1_gnt: got %b exp 0", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b exp 0", bus.mem_we); else n_pass++;
    n_total++; if (bus.p0_rvalid !== 1'b0) $display("FAIL rst_p0_rvalid: got %b exp 0", bus.p0_rvalid); else n_pass++;
    n_total++; if (bus.p1_rvalid !== 1'b0) $display("FAIL rst_p1_rvalid: got %b exp 0", bus.p1_rvalid); else n_pass++;
    n_total++; if (bus.p0_err !== 1'b0) $display("FAIL rst_p0_err: got %b exp 0", bus.p0_err); else n_pass++;
    n_total++; if (bus.p1_err !== 1'b0) $display("FAIL rst_p1_err: got %b exp 0", bus.p1_err); else n_pass++;
    n_total++; if (bus.lock_owner !== 2'b00) $display("FAIL rst_lock_owner: got %b exp 00", bus.lock_owner); else n_pass++;
    n_total++; if (bus.lock_timeout !== 1'b0) $display("FAIL rst_lock_timeout: got %b exp 0", bus.lock_timeout); else n_pass++;
    step();
    rst_n = 1'b1;
    idle();
    step();
  endtask

  task automatic test_write_read();
    drive0(1'b1, 9'h012, 16'hBEEF, 1'b0);
    mid();
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t1_wr_gnt: got %b exp 1", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b1) $display("FAIL t1_wr_mem_we: got %b exp 1", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h12) $display("FAIL t1_wr_mem_addr: got %h exp 12", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'hBEEF) $display("FAIL t1_wr_mem_wdata: got %h exp beef", bus.mem_wdata); else n_pass++;
    step();
    drive0(1'b0, 9'h012, 16'h0000, 1'b0);
    mid();
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t1_rd_gnt: got %b exp 1", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL t1_rd_mem_we: got %b exp 0", bus.mem_we); else n_pass++;
    step();
    idle();
    mid();
    n_total++; if (bus.p0_rvalid !== 1'b1) $display("FAIL t1_rvalid: got %b exp 1", bus.p0_rvalid); else n_pass++;
    n_total++; if (bus.p0_rdata !== 16'hBEEF) $display("FAIL t1_rdata: got %h exp beef", bus.p0_rdata); else n_pass++;
    n_total++; if (bus.p1_rvalid !== 1'b0) $display("FAIL t1_p1_rvalid: got %b exp 0", bus.p1_rvalid); else n_pass++;
    n_total++; if (bus.p1_rdata !== 16'h0000) $display("FAIL t1_p1_rdata: got %h exp 0", bus.p1_rdata); else n_pass++;
    n_total++; if (bus.p1_gnt !== 1'b0) $display("FAIL t1_p1_gnt: got %b exp 0", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h12) $display("FAIL t1_hold_addr: got %h exp 12", bus.mem_addr); else n_pass++;
    step();
    mid();
    n_total++; if (bus.p0_rvalid !== 1'b0) $display("FAIL t1_rvalid_end: got %b exp 0", bus.p0_rvalid); else n_pass++;
    n_total++; if (bus.p0_rdata !== 16'h0000) $display("FAIL t1_rdata_end: got %h exp 0", bus.p0_rdata); else n_pass++;
    step();
  endtask

  task automatic test_contention();
    logic e0;
    apply_reset();
    drive0(1'b0, 9'h020, 16'h0000, 1'b0);
    drive1(1'b0, 9'h021, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e0 = ((k % 2) == 0);
      mid();
      n_total++; if (bus.p0_gnt !== e0) $display("FAIL t2_p0_gnt[%0d]: got %b exp %b", k, bus.p0_gnt, e0); else n_pass++;
      n_total++; if (bus.p1_gnt !== !e0) $display("FAIL t2_p1_gnt[%0d]: got %b exp %b", k, bus.p1_gnt, !e0); else n_pass++;
      if (k > 0) begin
        n_total++; if (bus.p0_rvalid !== !e0) $display("FAIL t2_p0_rvalid[%0d]: got %b exp %b", k, bus.p0_rvalid, !e0); else n_pass++;
        n_total++; if (bus.p0_rdata !== (e0 ? 16'h0000 : 16'h1020)) $display("FAIL t2_p0_rdata[%0d]: got %h", k, bus.p0_rdata); else n_pass++;
        n_total++; if (bus.p1_rvalid !== e0) $display("FAIL t2_p1_rvalid[%0d]: got %b exp %b", k, bus.p1_rvalid, e0); else n_pass++;
        n_total++; if (bus.p1_rdata !== (e0 ? 16'h1021 : 16'h0000)) $display("FAIL t2_p1_rdata[%0d]: got %h", k, bus.p1_rdata); else n_pass++;
      end
      step();
    end
    idle();
    mid();
    n_total++; if (bus.p1_rvalid !== 1'b1) $display("FAIL t2_p1_rvalid_last: got %b exp 1", bus.p1_rvalid); else n_pass++;
    n_total++; if (bus.p1_rdata !== 16'h1021) $display("FAIL t2_p1_rdata_last: got %h exp 1021", bus.p1_rdata); else n_pass++;
    n_total++; if (bus.p0_rvalid !== 1'b0) $display("FAIL t2_p0_rvalid_last: got %b exp 0", bus.p0_rvalid); else n_pass++;
    step();
  endtask

  task automatic test_lock();
    apply_reset();
    drive0(1'b0, 9'h030, 16'h0000, 1'b1);
    drive1(1'b0, 9'h040, 16'h0000, 1'b0);
    mid();
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t3_lockrd_gnt: got %b exp 1", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.p1_gnt !== 1'b0) $display("FAIL t3_lockrd_p1_gnt: got %b exp 0", bus.p1_gnt); else n_pass++;
    step();
    bus.p0_req = 1'b0;
    mid();
    n_total++; if (bus.p1_gnt !== 1'b0) $display("FAIL t3_masked_p1_gnt: got %b exp 0", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.lock_owner !== 2'b01) $display("FAIL t3_owner_p0: got %b exp 01", bus.lock_owner); else n_pass++;
    n_total++; if (bus.p0_rdata !== 16'h1030) $display("FAIL t3_old_rdata: got %h exp 1030", bus.p0_rdata); else n_pass++;
    step();
    drive0(1'b1, 9'h030, 16'h1031, 1'b0);
    mid();
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t3_unlock_gnt: got %b exp 1", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.p1_gnt !== 1'b0) $display("FAIL t3_unlock_p1_gnt: got %b exp 0", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b1) $display("FAIL t3_unlock_mem_we: got %b exp 1", bus.mem_we); else n_pass++;
    step();
    bus.p0_req = 1'b0;
    mid();
    n_total++; if (bus.p1_gnt !== 1'b1) $display("FAIL t3_waiter_gnt: got %b exp 1", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.lock_owner !== 2'b00) $display("FAIL t3_owner_none: got %b exp 00", bus.lock_owner); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h40) $display("FAIL t3_waiter_addr: got %h exp 40", bus.mem_addr); else n_pass++;
    step();
    idle();
    drive0(1'b0, 9'h030, 16'h0000, 1'b0);
    mid();
    n_total++; if (bus.p1_rdata !== 16'h1040) $display("FAIL t3_waiter_rdata: got %h exp 1040", bus.p1_rdata); else n_pass++;
    step();
    idle();
    mid();
    n_total++; if (bus.p0_rdata !== 16'h1031) $display("FAIL t3_rmw_result: got %h exp 1031", bus.p0_rdata); else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    drive1(1'b0, 9'h050, 16'h0000, 1'b1);
    mid();
    n_total++; if (bus.p1_gnt !== 1'b1) $display("FAIL t4_take_gnt: got %b exp 1", bus.p1_gnt); else n_pass++;
    step();
    idle();
    drive0(1'b0, 9'h060, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      mid();
      n_total++; if (bus.p0_gnt !== 1'b0) $display("FAIL t4_blocked_gnt[%0d]: got %b exp 0", k, bus.p0_gnt); else n_pass++;
      n_total++; if (bus.lock_owner !== 2'b10) $display("FAIL t4_owner[%0d]: got %b exp 10", k, bus.lock_owner); else n_pass++;
      n_total++; if (bus.lock_timeout !== 1'b0) $display("FAIL t4_early_to[%0d]: got %b exp 0", k, bus.lock_timeout); else n_pass++;
      if (k == 0) begin
        n_total++; if (bus.p1_rdata !== 16'h1050) $display("FAIL t4_p1_rdata: got %h exp 1050", bus.p1_rdata); else n_pass++;
      end
      step();
    end
    mid();
    n_total++; if (bus.lock_timeout !== 1'b1) $display("FAIL t4_to_pulse: got %b exp 1", bus.lock_timeout); else n_pass++;
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t4_after_gnt: got %b exp 1", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.lock_owner !== 2'b00) $display("FAIL t4_owner_cleared: got %b exp 00", bus.lock_owner); else n_pass++;
    step();
    idle();
    mid();
    n_total++; if (bus.lock_timeout !== 1'b0) $display("FAIL t4_to_end: got %b exp 0", bus.lock_timeout); else n_pass++;
    n_total++; if (bus.p0_rdata !== 16'h1060) $display("FAIL t4_p0_rdata: got %h exp 1060", bus.p0_rdata); else n_pass++;
    step();
  endtask

  task automatic test_out_of_range();
    drive1(1'b1, 9'h1FF, 16'h1234, 1'b0);
    mid();
    n_total++; if (bus.p1_gnt !== 1'b1) $display("FAIL t5_wr_gnt: got %b exp 1", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL t5_wr_mem_we: got %b exp 0", bus.mem_we); else n_pass++;
    n_total++; if (bus.p1_err !== 1'b0) $display("FAIL t5_err_early: got %b exp 0", bus.p1_err); else n_pass++;
    step();
    drive1(1'b0, 9'h1FF, 16'h0000, 1'b0);
    mid();
    n_total++; if (bus.p1_err !== 1'b1) $display("FAIL t5_wr_err: got %b exp 1", bus.p1_err); else n_pass++;
    n_total++; if (bus.p1_rvalid !== 1'b0) $display("FAIL t5_wr_rvalid: got %b exp 0", bus.p1_rvalid); else n_pass++;
    step();
    drive1(1'b0, 9'h0FF, 16'h0000, 1'b0);
    mid();
    n_total++; if (bus.p1_err !== 1'b1) $display("FAIL t5_rd_err: got %b exp 1", bus.p1_err); else n_pass++;
    n_total++; if (bus.p1_rvalid !== 1'b1) $display("FAIL t5_rd_rvalid: got %b exp 1", bus.p1_rvalid); else n_pass++;
    n_total++; if (bus.p1_rdata !== 16'h0000) $display("FAIL t5_rd_rdata: got %h exp 0", bus.p1_rdata); else n_pass++;
    step();
    idle();
    mid();
    n_total++; if (bus.p1_rdata !== 16'h10FF) $display("FAIL t5_ram_ff: got %h exp 10ff", bus.p1_rdata); else n_pass++;
    n_total++; if (bus.p1_err !== 1'b0) $display("FAIL t5_inr_err: got %b exp 0", bus.p1_err); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_read();
    drive0(1'b0, 9'h070, 16'h0000, 1'b1);
    mid();
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t6_gnt: got %b exp 1", bus.p0_gnt); else n_pass++;
    step();
    idle();
    rst_n = 1'b0;
    mid();
    n_total++; if (bus.p0_rvalid !== 1'b0) $display("FAIL t6_rvalid_in_rst: got %b exp 0", bus.p0_rvalid); else n_pass++;
    n_total++; if (bus.p0_rdata !== 16'h0000) $display("FAIL t6_rdata_in_rst: got %h exp 0", bus.p0_rdata); else n_pass++;
    step();
    mid();
    n_total++; if (bus.lock_owner !== 2'b00) $display("FAIL t6_owner: got %b exp 00", bus.lock_owner); else n_pass++;
    step();
    rst_n = 1'b1;
    drive0(1'b0, 9'h020, 16'h0000, 1'b0);
    drive1(1'b0, 9'h021, 16'h0000, 1'b0);
    mid();
    n_total++; if (bus.p0_gnt !== 1'b1) $display("FAIL t6_p0_wins: got %b exp 1", bus.p0_gnt); else n_pass++;
    n_total++; if (bus.p1_gnt !== 1'b0) $display("FAIL t6_p1_loses: got %b exp 0", bus.p1_gnt); else n_pass++;
    n_total++; if (bus.p0_rvalid !== 1'b0) $display("FAIL t6_no_stale_rvalid: got %b exp 0", bus.p0_rvalid); else n_pass++;
    step();
    idle();
    mid();
    n_total++; if (bus.p0_rdata !== 16'h1020) $display("FAIL t6_rdata: got %h exp 1020", bus.p0_rdata); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_timeout();
    test_out_of_range();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
